// File: rtl/execute_stage.sv
// EX stage of a 5-stage MIPS pipeline: ALU, branch target and destination mux feeding the EX/MEM register.
// One-cycle latency; ex_stall holds the register, ex_flush injects a bubble (control fields cleared).
module execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  id_ex_wb,
   input  logic [2:0]  id_ex_mem,
   input  logic [3:0]  id_ex_execute,
   input  logic [31:0] id_ex_npc,
   input  logic [31:0] id_ex_readdat1,
   input  logic [31:0] id_ex_readdat2,
   input  logic [31:0] id_ex_sign_ext,
   input  logic [4:0]  id_ex_instr_bits_20_16,
   input  logic [4:0]  id_ex_instr_bits_15_11,
   input  logic        ex_stall,
   input  logic        ex_flush,
   output logic [1:0]  ex_mem_wb,
   output logic [2:0]  ex_mem_mem,
   output logic [31:0] ex_mem_branch_target,
   output logic        ex_mem_zero,
   output logic [31:0] ex_mem_alu_result,
   output logic [31:0] ex_mem_readdat2,
   output logic [4:0]  ex_mem_write_reg
);

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   logic        reg_dst;
   logic        alu_src;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] op_b;
   logic [31:0] alu_res;
   logic [31:0] branch_tgt;
   logic [4:0]  write_reg;

   assign reg_dst    = id_ex_execute[3];
   assign alu_src    = id_ex_execute[2];
   assign alu_op     = id_ex_execute[1:0];
   assign funct      = id_ex_sign_ext[5:0];
   assign op_b       = alu_src ? id_ex_sign_ext : id_ex_readdat2;
   assign branch_tgt = id_ex_npc + {id_ex_sign_ext[29:0], 2'b00};
   assign write_reg  = reg_dst ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;

   always_comb begin
      alu_res = 32'h0;
      case (alu_op)
         2'b00, 2'b11: alu_res = id_ex_readdat1 + op_b;
         2'b01:        alu_res = id_ex_readdat1 - op_b;
         default: begin
            // Unrecognised funct codes yield zero rather than an arbitrary op.
            case (funct)
               FUNCT_ADD: alu_res = id_ex_readdat1 + op_b;
               FUNCT_SUB: alu_res = id_ex_readdat1 - op_b;
               FUNCT_AND: alu_res = id_ex_readdat1 & op_b;
               FUNCT_OR:  alu_res = id_ex_readdat1 | op_b;
               FUNCT_SLT: alu_res = {31'b0, $signed(id_ex_readdat1) < $signed(op_b)};
               default:   alu_res = 32'h0;
            endcase
         end
      endcase
   end

   logic [1:0]  wb_q,     wb_d;
   logic [2:0]  mem_q,    mem_d;
   logic [31:0] bt_q,     bt_d;
   logic        zero_q,   zero_d;
   logic [31:0] alu_q,    alu_d;
   logic [31:0] rd2_q,    rd2_d;
   logic [4:0]  wreg_q,   wreg_d;

   always_comb begin
      wb_d   = wb_q;
      mem_d  = mem_q;
      bt_d   = bt_q;
      zero_d = zero_q;
      alu_d  = alu_q;
      rd2_d  = rd2_q;
      wreg_d = wreg_q;
      if (ex_flush || !ex_stall) begin
         // A flushed slot still carries data; only the control fields become a bubble.
         wb_d   = ex_flush ? 2'b00  : id_ex_wb;
         mem_d  = ex_flush ? 3'b000 : id_ex_mem;
         bt_d   = branch_tgt;
         zero_d = (alu_res == 32'h0);
         alu_d  = alu_res;
         rd2_d  = id_ex_readdat2;
         wreg_d = write_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= 2'b00;
         mem_q  <= 3'b000;
         bt_q   <= 32'h0;
         zero_q <= 1'b0;
         alu_q  <= 32'h0;
         rd2_q  <= 32'h0;
         wreg_q <= 5'h0;
      end else begin
         wb_q   <= wb_d;
         mem_q  <= mem_d;
         bt_q   <= bt_d;
         zero_q <= zero_d;
         alu_q  <= alu_d;
         rd2_q  <= rd2_d;
         wreg_q <= wreg_d;
      end
   end

   assign ex_mem_wb            = wb_q;
   assign ex_mem_mem           = mem_q;
   assign ex_mem_branch_target = bt_q;
   assign ex_mem_zero          = zero_q;
   assign ex_mem_alu_result    = alu_q;
   assign ex_mem_readdat2      = rd2_q;
   assign ex_mem_write_reg     = wreg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: random and directed instructions against a behavioural model.
module tb_execute_stage;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  mem;
      logic [31:0] bt;
      logic        zero;
      logic [31:0] alu;
      logic [31:0] rd2;
      logic [4:0]  wreg;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  id_ex_wb = '0;
   logic [2:0]  id_ex_mem = '0;
   logic [3:0]  id_ex_execute = '0;
   logic [31:0] id_ex_npc = '0;
   logic [31:0] id_ex_readdat1 = '0;
   logic [31:0] id_ex_readdat2 = '0;
   logic [31:0] id_ex_sign_ext = '0;
   logic [4:0]  id_ex_instr_bits_20_16 = '0;
   logic [4:0]  id_ex_instr_bits_15_11 = '0;
   logic        ex_stall = 1'b0;
   logic        ex_flush = 1'b0;
   logic [1:0]  ex_mem_wb;
   logic [2:0]  ex_mem_mem;
   logic [31:0] ex_mem_branch_target;
   logic        ex_mem_zero;
   logic [31:0] ex_mem_alu_result;
   logic [31:0] ex_mem_readdat2;
   logic [4:0]  ex_mem_write_reg;

   execute_stage dut (
      .clk(clk), .rst(rst),
      .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem), .id_ex_execute(id_ex_execute),
      .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
      .id_ex_sign_ext(id_ex_sign_ext),
      .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16),
      .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
      .ex_stall(ex_stall), .ex_flush(ex_flush),
      .ex_mem_wb(ex_mem_wb), .ex_mem_mem(ex_mem_mem),
      .ex_mem_branch_target(ex_mem_branch_target), .ex_mem_zero(ex_mem_zero),
      .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_readdat2(ex_mem_readdat2),
      .ex_mem_write_reg(ex_mem_write_reg)
   );

   always #5 clk = ~clk;

   out_t dut_out;
   assign dut_out = '{ex_mem_wb, ex_mem_mem, ex_mem_branch_target, ex_mem_zero,
                      ex_mem_alu_result, ex_mem_readdat2, ex_mem_write_reg};

   out_t sb[$];
   out_t model_q = '0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   done = 1'b0;

   function automatic void chk(string nm, logic [106:0] act, logic [106:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction

   // Architectural meaning of the current ID/EX contents.
   function automatic out_t ref_ex();
      out_t        r;
      logic [31:0] a, b, res;
      a = id_ex_readdat1;
      b = id_ex_execute[2] ? id_ex_sign_ext : id_ex_readdat2;
      res = 32'h0;
      if (id_ex_execute[1:0] == 2'b01) res = a - b;
      else if (id_ex_execute[1:0] != 2'b10) res = a + b;
      else if (id_ex_sign_ext[5:0] == 6'd32) res = a + b;
      else if (id_ex_sign_ext[5:0] == 6'd34) res = a - b;
      else if (id_ex_sign_ext[5:0] == 6'd36) res = a & b;
      else if (id_ex_sign_ext[5:0] == 6'd37) res = a | b;
      else if (id_ex_sign_ext[5:0] == 6'd42) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      r.wb   = id_ex_wb;
      r.mem  = id_ex_mem;
      r.bt   = id_ex_npc + id_ex_sign_ext * 4;
      r.zero = (res == 0);
      r.alu  = res;
      r.rd2  = id_ex_readdat2;
      r.wreg = id_ex_execute[3] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
      return r;
   endfunction

   // Push the expected register contents for the coming edge, then move past it.
   task automatic step();
      out_t e;
      if (rst) e = '0;
      else if (ex_flush) begin
         e = ref_ex();
         e.wb = 2'b00;
         e.mem = 3'b000;
      end else if (ex_stall) e = model_q;
      else e = ref_ex();
      model_q = e;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic rand_instr();
      logic [5:0] functs [6];
      functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
      id_ex_wb       = 2'($urandom);
      id_ex_mem      = 3'($urandom);
      id_ex_execute  = 4'($urandom);
      id_ex_npc      = $urandom;
      id_ex_readdat1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      id_ex_readdat2 = ($urandom_range(0, 3) == 0) ? id_ex_readdat1 : $urandom;
      id_ex_sign_ext = {{16{1'($urandom)}}, 10'($urandom), functs[$urandom_range(0, 5)]};
      if ($urandom_range(0, 7) == 0) id_ex_sign_ext[5:0] = 6'($urandom);
      id_ex_instr_bits_20_16 = 5'($urandom);
      id_ex_instr_bits_15_11 = 5'($urandom);
   endtask

   initial begin : monitor
      out_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            if (!done) chk("sb_underflow", 107'd1, 107'd0);
         end else begin
            e = sb.pop_front();
            chk("ex_mem_reg", dut_out, e);
         end
      end
   end

   initial begin : driver
      rst = 1'b1; ex_stall = 1'b1; ex_flush = 1'b1;
      rand_instr();
      step();
      step();
      chk("reset_all_zero", dut_out, 107'd0);
      rst = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;

      // R-type add
      id_ex_wb = 2'b10; id_ex_mem = 3'b000; id_ex_execute = 4'b1010;
      id_ex_readdat1 = 32'd5; id_ex_readdat2 = 32'd7; id_ex_sign_ext = 32'h20;
      id_ex_instr_bits_15_11 = 5'd9; id_ex_instr_bits_20_16 = 5'd4; id_ex_npc = 32'h40;
      step();
      chk("radd_alu", ex_mem_alu_result, 32'd12);
      chk("radd_zero", ex_mem_zero, 1'b0);
      chk("radd_wreg", ex_mem_write_reg, 5'd9);
      chk("radd_ctl", {ex_mem_wb, ex_mem_mem}, 5'b10000);

      // beq taken
      id_ex_wb = 2'b00; id_ex_mem = 3'b100; id_ex_execute = 4'b0001;
      id_ex_readdat1 = 32'h1234; id_ex_readdat2 = 32'h1234;
      id_ex_npc = 32'h100; id_ex_sign_ext = 32'h4;
      step();
      chk("beq_zero", ex_mem_zero, 1'b1);
      chk("beq_target", ex_mem_branch_target, 32'h110);

      // lw with negative offset; branch target wraps below npc
      id_ex_wb = 2'b11; id_ex_mem = 3'b010; id_ex_execute = 4'b0100;
      id_ex_readdat1 = 32'h1000; id_ex_sign_ext = 32'hFFFF_FFFC;
      id_ex_instr_bits_20_16 = 5'd3; id_ex_npc = 32'h20;
      step();
      chk("lw_alu", ex_mem_alu_result, 32'hFFC);
      chk("lw_wreg", ex_mem_write_reg, 5'd3);
      chk("lw_target", ex_mem_branch_target, 32'h10);

      // signed slt, then wrapping add
      id_ex_execute = 4'b1010; id_ex_readdat1 = 32'hFFFF_FFFF; id_ex_readdat2 = 32'd1;
      id_ex_sign_ext = 32'h2A;
      step();
      chk("slt_neg", ex_mem_alu_result, 32'd1);
      id_ex_execute = 4'b0000;
      step();
      chk("add_wrap_alu", ex_mem_alu_result, 32'd0);
      chk("add_wrap_zero", ex_mem_zero, 1'b1);

      // unlisted funct
      id_ex_execute = 4'b1010; id_ex_sign_ext = 32'h3F; id_ex_readdat2 = 32'd9;
      step();
      chk("bad_funct_alu", ex_mem_alu_result, 32'd0);
      chk("bad_funct_zero", ex_mem_zero, 1'b1);

      // stall two cycles with changing inputs
      ex_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rand_instr();
         id_ex_readdat1 = 32'h77; id_ex_execute = 4'b0000;
         step();
         chk("stall_alu", ex_mem_alu_result, 32'd0);
         chk("stall_rd2", ex_mem_readdat2, 32'd9);
      end

      // stall + flush: flush wins, data still loads
      ex_flush = 1'b1; id_ex_wb = 2'b11; id_ex_mem = 3'b111;
      id_ex_execute = 4'b0000; id_ex_readdat1 = 32'd3; id_ex_readdat2 = 32'd4;
      step();
      chk("flush_ctl", {ex_mem_wb, ex_mem_mem}, 5'b00000);
      chk("flush_alu", ex_mem_alu_result, 32'd7);
      ex_flush = 1'b0;

      // reset during stall
      rst = 1'b1;
      step();
      chk("rst_in_stall", dut_out, 107'd0);
      rst = 1'b0; ex_stall = 1'b0;

      for (int i = 0; i < 400; i++) begin
         rand_instr();
         ex_stall = ($urandom_range(0, 4) == 0);
         ex_flush = ($urandom_range(0, 6) == 0);
         rst      = ($urandom_range(0, 40) == 0);
         step();
      end

      done = 1'b1;
      chk("sb_drained", 107'(sb.size()), 107'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
